// File: rtl/alu.sv
// RV32I execute-stage ALU with a registered result, zero flag and valid.
// Optional macro ALU_MUL_EN enables MUL on select code 1010.
module alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             out_valid
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    localparam logic [3:0] SEL_ADD   = 4'b0000;
    localparam logic [3:0] SEL_SLL   = 4'b0001;
    localparam logic [3:0] SEL_SLT   = 4'b0010;
    localparam logic [3:0] SEL_SLTU  = 4'b0011;
    localparam logic [3:0] SEL_XOR   = 4'b0100;
    localparam logic [3:0] SEL_SRL   = 4'b0101;
    localparam logic [3:0] SEL_OR    = 4'b0110;
    localparam logic [3:0] SEL_AND   = 4'b0111;
    localparam logic [3:0] SEL_SUB   = 4'b1000;
    localparam logic [3:0] SEL_PASSB = 4'b1001;
    localparam logic [3:0] SEL_MUL   = 4'b1010;
    localparam logic [3:0] SEL_SRA   = 4'b1101;

    logic [SHAMT_W-1:0] w_shamt;
    logic               w_lt_s;
    logic               w_lt_u;
    logic [WIDTH-1:0]   w_sra;
    logic [WIDTH-1:0]   w_mul;
    logic [WIDTH-1:0]   w_result;

    logic [WIDTH-1:0]   r_alu_out;
    logic               r_zero;
    logic               r_out_valid;

    // Only the low shift-amount bits of in2 are meaningful for shifts.
    assign w_shamt = in2[SHAMT_W-1:0];
    assign w_lt_s  = $signed(in1) < $signed(in2);
    assign w_lt_u  = in1 < in2;
    assign w_sra   = WIDTH'($unsigned($signed(in1) >>> w_shamt));

`ifdef ALU_MUL_EN
    assign w_mul = WIDTH'(in1 * in2);
`else
    assign w_mul = '0;
`endif

    // Result select; unused codes produce zero.
    always_comb begin
        w_result = '0;
        case (alu_sel)
            SEL_ADD:   w_result = in1 + in2;
            SEL_SUB:   w_result = in1 - in2;
            SEL_SLL:   w_result = in1 << w_shamt;
            SEL_SLT:   w_result = WIDTH'(w_lt_s);
            SEL_SLTU:  w_result = WIDTH'(w_lt_u);
            SEL_XOR:   w_result = in1 ^ in2;
            SEL_SRL:   w_result = in1 >> w_shamt;
            SEL_SRA:   w_result = w_sra;
            SEL_OR:    w_result = in1 | in2;
            SEL_AND:   w_result = in1 & in2;
            SEL_PASSB: w_result = in2;
            SEL_MUL:   w_result = w_mul;
            default:   w_result = '0;
        endcase
    end

    // Result and zero load only on valid issue; valid is a one-cycle copy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_out   <= '0;
            r_zero      <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_alu_out <= w_result;
                r_zero    <= (w_result == '0);
            end
        end
    end

    assign alu_out   = r_alu_out;
    assign zero      = r_zero;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the alu block (MUL expectation follows ALU_MUL_EN).
module tb_alu;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [3:0]       alu_sel;
    logic [WIDTH-1:0] alu_out;
    logic             zero;
    logic             out_valid;

    int checks;
    int failures;

    alu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in1       (in1),
        .in2       (in2),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .zero      (zero),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [WIDTH-1:0] e_out,
                           input logic e_zero, input logic e_valid);
        chk({tag, ".out"},   alu_out, e_out);
        chk({tag, ".zero"},  WIDTH'(zero), WIDTH'(e_zero));
        chk({tag, ".valid"}, WIDTH'(out_valid), WIDTH'(e_valid));
    endtask

    // Drive one cycle of inputs at the falling edge, then settle past the rising edge.
    task automatic op(input logic [3:0] sel, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic v);
        @(negedge clk);
        alu_sel  = sel;
        in1      = a;
        in2      = b;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in1      = 32'h0000_0005;
        in2      = 32'h0000_0006;
        alu_sel  = 4'b0000;

        // Reset held with valid asserted
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 32'h0, 1'b1, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        op(4'b0000, 32'h3, 32'h4, 1'b1);
        chk_all("first_after_reset", 32'h7, 1'b0, 1'b1);

        // 0xA sweep, one op per cycle
        op(4'b0000, 32'hA, 32'hA, 1'b1); chk_all("a_add",   32'h14,   1'b0, 1'b1);
        op(4'b0001, 32'hA, 32'hA, 1'b1); chk_all("a_sll",   32'h2800, 1'b0, 1'b1);
        op(4'b0010, 32'hA, 32'hA, 1'b1); chk_all("a_slt",   32'h0,    1'b1, 1'b1);
        op(4'b0011, 32'hA, 32'hA, 1'b1); chk_all("a_sltu",  32'h0,    1'b1, 1'b1);
        op(4'b0110, 32'hA, 32'hA, 1'b1); chk_all("a_or",    32'hA,    1'b0, 1'b1);
        op(4'b0111, 32'hA, 32'hA, 1'b1); chk_all("a_and",   32'hA,    1'b0, 1'b1);
        op(4'b0101, 32'hA, 32'hA, 1'b1); chk_all("a_srl",   32'h0,    1'b1, 1'b1);
        op(4'b1000, 32'hA, 32'hA, 1'b1); chk_all("a_sub",   32'h0,    1'b1, 1'b1);
        op(4'b1001, 32'hA, 32'hA, 1'b1); chk_all("a_passb", 32'hA,    1'b0, 1'b1);
        op(4'b0100, 32'hF0F0_1234, 32'h0FF0_1234, 1'b1);
        chk_all("xor", 32'hFF00_0000, 1'b0, 1'b1);

        // Signed vs unsigned compare
        op(4'b0010, 32'hFFFF_FFFF, 32'h1, 1'b1); chk_all("slt_neg",  32'h1, 1'b0, 1'b1);
        op(4'b0011, 32'hFFFF_FFFF, 32'h1, 1'b1); chk_all("sltu_big", 32'h0, 1'b1, 1'b1);

        // Shifts with upper shamt bits set
        op(4'b1101, 32'h8000_0000, 32'h24, 1'b1); chk_all("sra", 32'hF800_0000, 1'b0, 1'b1);
        op(4'b0101, 32'h8000_0000, 32'h24, 1'b1); chk_all("srl", 32'h0800_0000, 1'b0, 1'b1);
        op(4'b0001, 32'h8000_0000, 32'h24, 1'b1); chk_all("sll", 32'h0,         1'b1, 1'b1);
        op(4'b0001, 32'h1,         32'h21, 1'b1); chk_all("sll_mask", 32'h2,    1'b0, 1'b1);

        // Wrap, overflow and hold
        op(4'b0000, 32'h7FFF_FFFF, 32'h1, 1'b1); chk_all("ovf_add",  32'h8000_0000, 1'b0, 1'b1);
        op(4'b0000, 32'hFFFF_FFFF, 32'h1, 1'b1); chk_all("wrap_add", 32'h0,         1'b1, 1'b1);
        op(4'b0000, 32'h1234, 32'h1, 1'b0);      chk_all("hold_zero", 32'h0,        1'b1, 1'b0);
        op(4'b1000, 32'h0, 32'h1, 1'b1);         chk_all("sub_wrap", 32'hFFFF_FFFF, 1'b0, 1'b1);
        op(4'b0000, 32'h5, 32'h6, 1'b0);         chk_all("hold_val", 32'hFFFF_FFFF, 1'b0, 1'b0);
        op(4'b1111, 32'h5, 32'h6, 1'b1);         chk_all("undef",    32'h0,         1'b1, 1'b1);
        op(4'b1011, 32'h5, 32'h6, 1'b1);         chk_all("undef_b",  32'h0,         1'b1, 1'b1);

        op(4'b1010, 32'h0001_0003, 32'h0001_0002, 1'b1);
`ifdef ALU_MUL_EN
        chk_all("mul", 32'h0005_0006, 1'b0, 1'b1);
`else
        chk_all("mul_off", 32'h0, 1'b1, 1'b1);
`endif

        // Reset mid-stream drops the in-flight result
        op(4'b0000, 32'h10, 32'h20, 1'b1); chk_all("pre_rst", 32'h30, 1'b0, 1'b1);
        @(negedge clk);
        rst_n    = 1'b0;
        alu_sel  = 4'b0000;
        in1      = 32'h7;
        in2      = 32'h8;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk_all("mid_rst", 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        op(4'b0000, 32'h2, 32'h2, 1'b1); chk_all("post_rst", 32'h4, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
